// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory between fetch and data ports
module mem_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_write,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Port identifiers used for last_grant and the current owner of the memory.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // The wait counter is 4 bits wide, so WAIT_CYCLES is limited to 0..15.
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       last_grant;   // port served by the most recent completed access
    logic       cur_port;     // port owning the access in progress

    logic       grant_valid;
    logic       grant_port;

    // Grant decision: full round-robin in IDLE; in RESP only the port that was
    // not just served may win, since the served port still holds its req this cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = PORT_FETCH;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_valid = 1'b1;
                    grant_port  = (last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
                end else if (d_req) begin
                    grant_valid = 1'b1;
                    grant_port  = PORT_DATA;
                end else if (i_req) begin
                    grant_valid = 1'b1;
                    grant_port  = PORT_FETCH;
                end
            end
            RESP: begin
                if (last_grant == PORT_DATA) begin
                    grant_valid = i_req;
                    grant_port  = PORT_FETCH;
                end else begin
                    grant_valid = d_req;
                    grant_port  = PORT_DATA;
                end
            end
            default: begin
                grant_valid = 1'b0;
                grant_port  = PORT_FETCH;
            end
        endcase
    end

    // Access sequencer: registers the memory strobes, address, write data,
    // read data and the one-cycle acknowledges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            last_grant <= PORT_FETCH;
            cur_port   <= PORT_FETCH;
            mem_enable <= 1'b1;
            mem_write  <= 1'b1;
            mem_addr   <= '0;
            mem_in     <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (grant_valid) begin
                        cur_port   <= grant_port;
                        mem_addr   <= (grant_port == PORT_DATA) ? d_addr : i_addr;
                        mem_in     <= (grant_port == PORT_DATA) ? d_wdata : mem_in;
                        mem_write  <= ~((grant_port == PORT_DATA) && d_we);
                        mem_enable <= 1'b0;
                        wait_cnt   <= WAIT_INIT;
                        state      <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (cur_port == PORT_DATA) begin
                            d_ack <= 1'b1;
                            // mem_write is still low here for a write, which leaves d_rdata alone
                            if (mem_write) begin
                                d_rdata <= mem_out;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_out;
                        end
                        mem_enable <= 1'b1;
                        mem_write  <= 1'b1;
                        last_grant <= cur_port;
                        state      <= RESP;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_enable <= 1'b1;
                    mem_write  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with WAIT_CYCLES 0 and 3
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        i_req      [2];
    logic [19:0] i_addr     [2];
    logic [15:0] i_rdata    [2];
    logic        i_ack      [2];
    logic        d_req      [2];
    logic        d_we       [2];
    logic [19:0] d_addr     [2];
    logic [15:0] d_wdata    [2];
    logic [15:0] d_rdata    [2];
    logic        d_ack      [2];
    logic        mem_write  [2];
    logic        mem_enable [2];
    logic [19:0] mem_addr   [2];
    logic [15:0] mem_in     [2];
    logic [15:0] mem_out    [2];

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [15:0] ref_mem [2][1024];
    logic [15:0] exp_i   [2];
    logic [15:0] exp_d   [2];

    typedef struct {
        int          k;
        bit          fetch;
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 37) ^ 16'h5A5A;
    endfunction

    // Instance 0 has no wait states, instance 1 has three; each owns a small memory model.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mem [1024];

        mem_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(g * 3)) dut (
            .clk        (clk),
            .rst        (rst),
            .i_req      (i_req[g]),
            .i_addr     (i_addr[g]),
            .i_rdata    (i_rdata[g]),
            .i_ack      (i_ack[g]),
            .d_req      (d_req[g]),
            .d_we       (d_we[g]),
            .d_addr     (d_addr[g]),
            .d_wdata    (d_wdata[g]),
            .d_rdata    (d_rdata[g]),
            .d_ack      (d_ack[g]),
            .mem_write  (mem_write[g]),
            .mem_enable (mem_enable[g]),
            .mem_addr   (mem_addr[g]),
            .mem_in     (mem_in[g]),
            .mem_out    (mem_out[g])
        );

        assign mem_out[g] = mem_enable[g] ? 16'hDEAD : mem[mem_addr[g][9:0]];

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
        end

        always @(negedge clk) begin
            if (!mem_enable[g] && !mem_write[g]) mem[mem_addr[g][9:0]] = mem_in[g];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 0; i_addr[k] = '0;
            d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0; d_wdata[k] = '0;
        end
    endtask

    // One isolated transaction: exact latency, strobe widths, address/data and read data.
    task automatic run_vec(input vec_t v);
        int k, w, lat, en_low, we_low;
        k = v.k; w = k * 3; lat = 0; en_low = 0; we_low = 0;
        if (v.fetch) begin
            i_req[k] = 1; i_addr[k] = v.addr;
        end else begin
            d_req[k] = 1; d_we[k] = v.we; d_addr[k] = v.addr; d_wdata[k] = v.wdata;
        end
        for (int c = 1; c <= w + 5; c++) begin
            @(negedge clk);
            if (!mem_enable[k]) begin
                en_low++;
                check("vec_mem_addr", mem_addr[k], v.addr);
                if (!mem_write[k]) begin
                    we_low++;
                    check("vec_mem_in", mem_in[k], v.wdata);
                end
            end
            check("vec_stray_ack", v.fetch ? d_ack[k] : i_ack[k], 0);
            if (v.fetch ? i_ack[k] : d_ack[k]) begin
                lat = c;
                break;
            end
        end
        check("vec_latency", lat, 2 + w);
        check("vec_enable_cycles", en_low, 1 + w);
        check("vec_write_cycles", we_low, (!v.fetch && v.we) ? 1 + w : 0);
        if (v.fetch) begin
            check("vec_i_rdata", i_rdata[k], v.rdata);
            check("vec_d_rdata_hold", d_rdata[k], exp_d[k]);
            exp_i[k] = v.rdata;
        end else begin
            check("vec_i_rdata_hold", i_rdata[k], exp_i[k]);
            if (v.we) begin
                check("vec_d_rdata_hold", d_rdata[k], exp_d[k]);
                ref_mem[k][v.addr[9:0]] = v.wdata;
            end else begin
                check("vec_d_rdata", d_rdata[k], v.rdata);
                exp_d[k] = v.rdata;
            end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    // Random traffic on instance k, checked against a transaction-level model.
    task automatic random_test(input int k, input int ncyc);
        bit          pend [2];
        int          age  [2];
        bit          rr_exp;
        int          rr_port, since, p, served, w;
        logic [19:0] a;
        pend[0] = 0; pend[1] = 0; age[0] = 0; age[1] = 0;
        rr_exp = 0; rr_port = 0; since = 0; served = 0; w = k * 3;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            since++;
            if (!mem_enable[k] && !mem_write[k]) begin
                check("rand_write_owner", {pend[1], d_we[k]}, 2'b11);
                check("rand_write_addr", mem_addr[k], d_addr[k]);
                check("rand_write_data", mem_in[k], d_wdata[k]);
            end
            check("rand_ack_overlap", i_ack[k] & d_ack[k], 0);
            if (i_ack[k] || d_ack[k]) begin
                p = d_ack[k] ? 1 : 0;
                served++;
                check("rand_ack_pending", pend[p], 1);
                if (rr_exp) begin
                    check("rand_rr_port", p, rr_port);
                    check("rand_rr_gap", since, 2 + w);
                end
                if (p == 0) begin
                    exp_i[k] = ref_mem[k][i_addr[k][9:0]];
                    check("rand_i_rdata", i_rdata[k], exp_i[k]);
                    check("rand_d_hold", d_rdata[k], exp_d[k]);
                    i_req[k] = 0;
                end else begin
                    if (d_we[k]) begin
                        ref_mem[k][d_addr[k][9:0]] = d_wdata[k];
                    end else begin
                        exp_d[k] = ref_mem[k][d_addr[k][9:0]];
                    end
                    check("rand_d_rdata", d_rdata[k], exp_d[k]);
                    check("rand_i_hold", i_rdata[k], exp_i[k]);
                    d_req[k] = 0;
                end
                rr_exp = pend[1 - p];
                rr_port = 1 - p;
                since = 0;
                pend[p] = 0;
                age[p] = 0;
            end
            for (int q = 0; q < 2; q++) begin
                if (pend[q]) begin
                    age[q]++;
                    if (age[q] > 4 * (2 + w) + 4) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rand_timeout: port %0d waited %0d cycles, limit %0d", q, age[q], 4 * (2 + w) + 4);
                        return;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    a = 20'($urandom()) & 20'hFFC0F;
                    pend[q] = 1;
                    age[q] = 0;
                    if (q == 0) begin
                        i_req[k] = 1; i_addr[k] = a;
                    end else begin
                        d_req[k] = 1; d_addr[k] = a;
                        d_we[k] = 1'($urandom_range(0, 1));
                        d_wdata[k] = 16'($urandom());
                    end
                end
            end
        end
        check("rand_progress", served > 200, 1);
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_val(i);
            exp_i[k] = '0;
            exp_d[k] = '0;
        end

        tbl[0]  = '{0, 0, 1, 20'h00000, 16'd15,   16'h0000};
        tbl[1]  = '{0, 0, 0, 20'h00000, 16'h0000, 16'd15};
        tbl[2]  = '{0, 0, 1, 20'h00005, 16'd10,   16'h0000};
        tbl[3]  = '{0, 1, 0, 20'h00005, 16'h0000, 16'd10};
        tbl[4]  = '{0, 0, 1, 20'hFFFFF, 16'hFFFF, 16'h0000};
        tbl[5]  = '{0, 1, 0, 20'hFFFFF, 16'h0000, 16'hFFFF};
        tbl[6]  = '{0, 0, 0, 20'h00005, 16'h0000, 16'd10};
        tbl[7]  = '{0, 1, 0, 20'h00123, 16'h0000, init_val(20'h123)};
        tbl[8]  = '{1, 1, 0, 20'h00005, 16'h0000, init_val(5)};
        tbl[9]  = '{1, 0, 1, 20'h00040, 16'hBEEF, 16'h0000};
        tbl[10] = '{1, 0, 0, 20'h00040, 16'h0000, 16'hBEEF};
        tbl[11] = '{1, 1, 0, 20'h00040, 16'h0000, 16'hBEEF};

        // Reset values on both instances.
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_mem_enable", mem_enable[k], 1);
            check("rst_mem_write", mem_write[k], 1);
            check("rst_mem_addr", mem_addr[k], 0);
            check("rst_mem_in", mem_in[k], 0);
            check("rst_acks", {i_ack[k], d_ack[k]}, 0);
            check("rst_rdata", {i_rdata[k], d_rdata[k]}, 0);
        end
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        // Both ports requesting from reset and held: data, fetch, data, fetch in 8 cycles.
        rst = 1;
        i_req[0] = 1; i_addr[0] = 20'h00005;
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 20'h00000;
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 2; k++) begin exp_i[k] = '0; exp_d[k] = '0; end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("rr_d_ack", d_ack[0], (c == 2 || c == 6) ? 1 : 0);
            check("rr_i_ack", i_ack[0], (c == 4 || c == 8) ? 1 : 0);
            if (d_ack[0]) check("rr_d_rdata", d_rdata[0], 16'd15);
            if (i_ack[0]) check("rr_i_rdata", i_rdata[0], 16'd10);
        end
        exp_i[0] = 16'd10;
        exp_d[0] = 16'd15;
        clear_inputs();
        repeat (2) @(negedge clk);

        // Quiet bus: no strobes and no acks.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_enable", {mem_enable[0], mem_enable[1]}, 2'b11);
            check("idle_acks", {i_ack[0], d_ack[0], i_ack[1], d_ack[1]}, 0);
        end

        // Reset in the middle of a waited write: strobes release without a clock, no ack.
        d_req[1] = 1; d_we[1] = 1; d_addr[1] = 20'h00300; d_wdata[1] = 16'h1234;
        @(negedge clk);
        check("midrst_enable_low", mem_enable[1], 0);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        check("midrst_enable_async", mem_enable[1], 1);
        check("midrst_write_async", mem_write[1], 1);
        clear_inputs();
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 2; k++) begin exp_i[k] = '0; exp_d[k] = '0; end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("midrst_no_ack", {i_ack[1], d_ack[1]}, 0);
            check("midrst_enable", mem_enable[1], 1);
        end

        random_test(0, 3000);
        random_test(1, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
